alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc_pkg.sv | 36 +++
 rtl/alu_mc_mul_iter.sv | 49 ++++
 rtl/alu_mc.sv | 138 +++++++++++++
 tb/tb_alu_mc.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// Shared encodings for the multi-cycle ALU: op codes, FSM states, flag bit positions.
// Optional feature macro: ALU_MC_SMULL_EN (signed long multiply on op 110).
package alu_mc_pkg;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_MUL   = 3'b100,
    ALU_UMULL = 3'b101,
    ALU_SMULL = 3'b110,
    ALU_RSVD  = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_FIN
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Ops that go through the iterative multiplier; everything else finishes in one cycle.
  function automatic logic is_mul_op(input alu_op_t op);
`ifdef ALU_MC_SMULL_EN
    return (op == ALU_MUL) || (op == ALU_UMULL) || (op == ALU_SMULL);
`else
    return (op == ALU_MUL) || (op == ALU_UMULL);
`endif
  endfunction

endpackage

// File: rtl/alu_mc_mul_iter.sv
// Radix-2 shift-add multiplier core: one multiplier bit per step, WIDTH steps per product.
// Unsigned only; sign handling for SMULL lives in the top (macro ALU_MC_SMULL_EN).
module alu_mc_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] product,
  output logic               last
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH:0]     acc;

  // Low half starts as the multiplier and drains out as the product shifts in from the top.
  // NOTE: every signal driven in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    acc    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_d = {acc, prod_q[WIDTH-1:1]};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      mcand_q <= mcand;
      prod_q  <= {{WIDTH{1'b0}}, mplier};
      cnt_q   <= '0;
    end else if (step) begin
      prod_q  <= prod_d;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  assign product = prod_q;
  assign last    = step && (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle add/sub/logic, iterative multiply, registered results with done pulse.
// Macro ALU_MC_SMULL_EN enables signed long multiply; otherwise op 110 acts as reserved.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ALUControl,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Result2,
  output logic [3:0]       ALUFlags
);

  state_t             state_q, state_d;
  alu_op_t            op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               done_q;
  logic [WIDTH-1:0]   result_q, result2_q;
  logic [3:0]         flags_q;

  logic               accept, mul_last;
  logic [WIDTH-1:0]   mcand, mplier, bx, res_lo, res_hi;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] product, full;
  logic [3:0]         flags_d;
  logic               wide;

  // Busy covers the done cycle too, so a new request is taken no earlier than the cycle after done.
  assign busy   = (state_q != S_IDLE) || done_q;
  assign accept = start && !busy;

`ifdef ALU_MC_SMULL_EN
  logic signed_op, neg_q;
  assign signed_op = (alu_op_t'(ALUControl) == ALU_SMULL);
  // Magnitude of the most-negative value is 2**(WIDTH-1), which still fits unsigned.
  assign mcand  = (signed_op && a[WIDTH-1]) ? -a : a;
  assign mplier = (signed_op && b[WIDTH-1]) ? -b : b;
  assign full   = neg_q ? -product : product;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    neg_q <= 1'b0;
    else if (accept) neg_q <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
  end
`else
  assign mcand  = a;
  assign mplier = b;
  assign full   = product;
`endif

  alu_mc_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (accept && is_mul_op(alu_op_t'(ALUControl))),
    .step    (state_q == S_MUL),
    .mcand   (mcand),
    .mplier  (mplier),
    .product (product),
    .last    (mul_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = is_mul_op(alu_op_t'(ALUControl)) ? S_MUL : S_FIN;
      S_MUL:   if (mul_last) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    res_lo  = '0;
    res_hi  = '0;
    flags_d = '0;
    bx      = op_q[0] ? ~b_q : b_q;
    sum     = {1'b0, a_q} + {1'b0, bx} + {{WIDTH{1'b0}}, op_q[0]};
    wide    = (op_q == ALU_UMULL);
    case (op_q)
      ALU_ADD, ALU_SUB: begin
        res_lo          = sum[WIDTH-1:0];
        flags_d[FLAG_C] = sum[WIDTH];
        flags_d[FLAG_V] = (a_q[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      ALU_AND:   res_lo = a_q & b_q;
      ALU_OR:    res_lo = a_q | b_q;
      ALU_MUL:   res_lo = product[WIDTH-1:0];
      ALU_UMULL: {res_hi, res_lo} = product;
`ifdef ALU_MC_SMULL_EN
      ALU_SMULL: begin
        {res_hi, res_lo} = full;
        wide             = 1'b1;
      end
`endif
      default: ;
    endcase
    flags_d[FLAG_N] = wide ? res_hi[WIDTH-1] : res_lo[WIDTH-1];
    flags_d[FLAG_Z] = wide ? ({res_hi, res_lo} == '0) : (res_lo == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      op_q      <= ALU_ADD;
      a_q       <= '0;
      b_q       <= '0;
      done_q    <= 1'b0;
      result_q  <= '0;
      result2_q <= '0;
      flags_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_FIN);
      if (accept) begin
        op_q <= alu_op_t'(ALUControl);
        a_q  <= a;
        b_q  <= b;
      end
      if (state_q == S_FIN) begin
        result_q  <= res_lo;
        result2_q <= res_hi;
        flags_q   <= flags_d;
      end
    end
  end

  assign done     = done_q;
  assign Result   = result_q;
  assign Result2  = result2_q;
  assign ALUFlags = flags_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc (WIDTH=32): directed corner cases plus random ops vs. an arithmetic model.
// Follows ALU_MC_SMULL_EN the same way as the design build.
module tb_alu_mc;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [W-1:0]   a, b;
  logic [2:0]     ALUControl;
  logic           start;
  logic           busy, done;
  logic [W-1:0]   Result, Result2;
  logic [3:0]     ALUFlags;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic [3:0]   flags;
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t         sb_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [W-1:0] held_lo = '0, held_hi = '0;
  logic [3:0]   held_flags = '0;

  alu_mc #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .a          (a),
    .b          (b),
    .ALUControl (ALUControl),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .Result     (Result),
    .Result2    (Result2),
    .ALUFlags   (ALUFlags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the architectural definition of each op.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        e;
    longint      sx, sy, s;
    logic [63:0] wide_v, p;
    logic        is_wide, c, v;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.lo = '0; e.hi = '0; e.lat = 1; e.acc_cyc = 0;
    is_wide = 1'b0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin
        wide_v = 64'(x) + 64'(y);
        e.lo = wide_v[W-1:0]; c = wide_v[W];
        s = sx + sy; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd1: begin
        e.lo = x - y; c = (x >= y);
        s = sx - sy; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd2: e.lo = x & y;
      3'd3: e.lo = x | y;
      3'd4: begin p = 64'(x) * 64'(y); e.lo = p[W-1:0]; e.lat = W + 1; end
      3'd5: begin p = 64'(x) * 64'(y); {e.hi, e.lo} = p; is_wide = 1'b1; e.lat = W + 1; end
`ifdef ALU_MC_SMULL_EN
      3'd6: begin p = 64'(sx * sy); {e.hi, e.lo} = p; is_wide = 1'b1; e.lat = W + 1; end
`endif
      default: ;
    endcase
    if (is_wide) e.flags = {e.hi[W-1], ({e.hi, e.lo} == 64'd0), 1'b0, 1'b0};
    else         e.flags = {e.lo[W-1], (e.lo == '0), c, v};
    return e;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      $display("FAIL busy_timeout: busy stuck high");
      errors++;
      checks++;
      return;
    end
    ALUControl = op; a = x; b = y; start = 1'b1;
    e = model(op, x, y);
    @(posedge clk);
    #1;
    e.acc_cyc = cyc;
    sb_q.push_back(e);
    start = 1'b0;
    a = $urandom; b = $urandom; ALUControl = 3'($urandom);
  endtask

  // Monitor: pops one expectation per done pulse; between pulses outputs must hold.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) continue;
      if (done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("Result", Result, e.lo);
          check("Result2", Result2, e.hi);
          check("ALUFlags", ALUFlags, e.flags);
          check("latency", cyc - e.acc_cyc, e.lat);
          check("busy_in_done", busy, 1);
          held_lo = e.lo; held_hi = e.hi; held_flags = e.flags;
        end
      end else begin
        check("hold", {Result, Result2[W-1:4], ALUFlags}, {held_lo, held_hi[W-1:4], held_flags});
      end
    end
  end

  initial begin
    int n;
    reset_n = 1'b0; start = 1'b0; a = '0; b = '0; ALUControl = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", {Result, Result2}, 64'd0);
    check("rst_flags", ALUFlags, 0);
    @(posedge clk); #2 reset_n = 1'b1;

    issue(3'd0, 32'h7FFFFFFF, 32'h00000001);
    issue(3'd1, 32'd5, 32'd5);
    issue(3'd2, 32'hF0F0F0F0, 32'h0FF00FF0);
    issue(3'd3, 32'h12340000, 32'h00005678);
    issue(3'd5, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(3'd6, 32'hFFFFFFFE, 32'h00000003);
    issue(3'd6, 32'h80000000, 32'h80000000);
    issue(3'd4, 32'h00010000, 32'h00010000);
    issue(3'd7, 32'hDEADBEEF, 32'h12345678);
    issue(3'd1, 32'd0, 32'd1);

    // Start pulsed mid-multiply with new operands must be ignored.
    issue(3'd5, 32'h00000003, 32'h00000005);
    repeat (4) @(negedge clk);
    check("busy_during_mul", busy, 1);
    ALUControl = 3'd0; a = 32'h11111111; b = 32'h22222222; start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Reset at iteration 10 of UMULL: outputs clear at once, no done.
    issue(3'd5, 32'hFFFFFFFF, 32'h12345678);
    repeat (9) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_result", {Result, Result2}, 64'd0);
    check("abort_flags", ALUFlags, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    sb_q.delete();
    held_lo = '0; held_hi = '0; held_flags = '0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    issue(3'd0, 32'd1, 32'd2);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] x, y;
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 3))
        0: x = 32'h80000000;
        1: y = (i % 2 == 0) ? 32'hFFFFFFFF : 32'h7FFFFFFF;
        default: ;
      endcase
      issue(3'($urandom_range(0, 7)), x, y);
    end

    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("drain", sb_q.size(), 0);
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
